irrigacao_multicanal: RTL

Parametrised successor of the single-sector irrigation controller. Serves N_CANAIS sectors round-robin, one at a time. For each sector it decides sprinkler, drip or agro-defensive application from that sector's soil/air/temperature inputs, then runs a 2-digit BCD countdown per phase. Sits between the debouncer and the decoder/display scan; its unidade/dezena/estado outputs feed the existing 7-segment path.

---
 rtl/irrigacao_pkg.sv | 32 +++
 rtl/irrigacao_multicanal_if.sv | 33 +++
 rtl/contador_bcd_regressivo.sv | 53 +++++
 rtl/irrigacao_multicanal.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/irrigacao_pkg.sv
// Shared types, BCD constants and elaboration-time parameter checks for the
// multi-sector irrigation controller.
package irrigacao_pkg;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    AVALIA      = 3'd1,
    ASPERSAO    = 3'd2,
    GOTEJAMENTO = 3'd3,
    AGRODEF     = 3'd4,
    PAUSA       = 3'd5
  } estado_t;

  localparam logic [3:0] BCD_ZERO = 4'd0;
  localparam logic [3:0] BCD_UM   = 4'd1;
  localparam logic [3:0] BCD_NOVE = 4'd9;
  localparam logic [7:0] BCD_00   = 8'h00;

  function automatic bit preset_valido(input int v);
    return (v >= 1) && (v <= 99);
  endfunction

  function automatic bit cw_valido(input int n, input int cw);
    return (n >= 2) && (n <= 16) && (cw == $clog2(n));
  endfunction

  // Packs a 0..99 preset into {tens, units} BCD.
  function automatic logic [7:0] para_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/irrigacao_multicanal_if.sv
// Control/sensor/actuator bundle between the debouncer side and the
// irrigation controller; clock and reset stay outside.
interface irrigacao_multicanal_if #(
  parameter int N_CANAIS = 4,
  parameter int CW       = 2
);
  logic                botao;
  logic [N_CANAIS-1:0] us;
  logic [N_CANAIS-1:0] ua;
  logic [N_CANAIS-1:0] t;
  logic [N_CANAIS-1:0] agrodef_req;
  logic [CW-1:0]       canal_ativo;
  logic [2:0]          estado;
  logic [3:0]          unidade;
  logic [3:0]          dezena;
  logic [N_CANAIS-1:0] valv_asp;
  logic [N_CANAIS-1:0] valv_got;
  logic [N_CANAIS-1:0] bomba_agro;
  logic [N_CANAIS-1:0] pendente;
  logic                ocupado;

  modport master (
    output botao, us, ua, t, agrodef_req,
    input  canal_ativo, estado, unidade, dezena,
           valv_asp, valv_got, bomba_agro, pendente, ocupado
  );

  modport slave (
    input  botao, us, ua, t, agrodef_req,
    output canal_ativo, estado, unidade, dezena,
           valv_asp, valv_got, bomba_agro, pendente, ocupado
  );
endinterface

// File: rtl/contador_bcd_regressivo.sv
// Two-digit BCD down-counter with its own 1 s prescaler; fim pulses on the
// tick that would take the count below 01.
module contador_bcd_regressivo
  import irrigacao_pkg::*;
#(
  parameter int PRESCALE = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       habilita,
  input  logic [7:0] valor_bcd,
  output logic [3:0] unidade,
  output logic [3:0] dezena,
  output logic       fim
);
  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = habilita && (presc == PW'(PRESCALE - 1));
  assign fim  = tick && (dezena == BCD_ZERO) && (unidade == BCD_UM);

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      unidade <= BCD_ZERO;
      dezena  <= BCD_ZERO;
    end else if (load) begin
      {dezena, unidade} <= valor_bcd;
      presc             <= '0;
    end else if (!habilita) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
      // The final tick leaves 01 on display; the owner reloads on fim.
      if (!fim) begin
        if (unidade == BCD_ZERO) begin
          unidade <= BCD_NOVE;
          dezena  <= dezena - 4'd1;
        end else begin
          unidade <= unidade - 4'd1;
        end
      end
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/irrigacao_multicanal.sv
// Round-robin irrigation controller: evaluates each sector, runs one timed
// phase (sprinkler, drip or agro-defensive) and a pause, then moves on.
module irrigacao_multicanal
  import irrigacao_pkg::*;
#(
  parameter int N_CANAIS = 4,
  parameter int CW       = 2,
  parameter int PRESCALE = 50_000_000,
  parameter int T_ASP    = 30,
  parameter int T_GOT    = 15,
  parameter int T_AGRO   = 20,
  parameter int T_PAUSA  = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  irrigacao_multicanal_if.slave bus
);
  if (!cw_valido(N_CANAIS, CW)) begin : g_err_cw
    $error("N_CANAIS must be 2..16 and CW must equal clog2(N_CANAIS)");
  end
  if (!(preset_valido(T_ASP) && preset_valido(T_GOT) &&
        preset_valido(T_AGRO) && preset_valido(T_PAUSA))) begin : g_err_preset
    $error("phase presets must lie in 1..99");
  end
  if (PRESCALE < 2) begin : g_err_prescale
    $error("PRESCALE must be at least 2");
  end

  localparam logic [7:0]    BCD_ASP   = para_bcd(T_ASP);
  localparam logic [7:0]    BCD_GOT   = para_bcd(T_GOT);
  localparam logic [7:0]    BCD_AGRO  = para_bcd(T_AGRO);
  localparam logic [7:0]    BCD_PAUSA = para_bcd(T_PAUSA);
  localparam logic [CW-1:0] ULTIMO    = CW'(N_CANAIS - 1);
  localparam logic [N_CANAIS-1:0] UM  = N_CANAIS'(1);

  estado_t             estado_q, estado_n;
  logic [CW-1:0]       ptr_q, ptr_n;
  logic [N_CANAIS-1:0] pend_q, asp_q, got_q, agro_q;
  logic [N_CANAIS-1:0] sel_n, limpa_vec;
  logic                ocup_q, load, limpa, fim, habilita;
  logic [7:0]          valor;

  assign habilita = estado_q inside {ASPERSAO, GOTEJAMENTO, AGRODEF, PAUSA};

  contador_bcd_regressivo #(.PRESCALE(PRESCALE)) u_contador (
    .clk       (clock),
    .rst_n     (reset_n),
    .load      (load),
    .habilita  (habilita),
    .valor_bcd (valor),
    .unidade   (bus.unidade),
    .dezena    (bus.dezena),
    .fim       (fim)
  );

  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    estado_n = estado_q;
    ptr_n    = ptr_q;
    load     = 1'b0;
    valor    = BCD_00;
    limpa    = 1'b0;
    // Abort outranks any phase end landing on the same cycle.
    if (bus.botao && estado_q != OCIOSO) begin
      estado_n = OCIOSO;
      ptr_n    = '0;
      load     = 1'b1;
    end else begin
      case (estado_q)
        OCIOSO: if (bus.botao) begin
          estado_n = AVALIA;
          ptr_n    = '0;
        end
        AVALIA: begin
          if (pend_q[ptr_q]) begin
            estado_n = AGRODEF;
            load     = 1'b1;
            valor    = BCD_AGRO;
            limpa    = 1'b1;
          end else if (bus.us[ptr_q]) begin
            load = 1'b1;
            if (bus.t[ptr_q] || !bus.ua[ptr_q]) begin
              estado_n = GOTEJAMENTO;
              valor    = BCD_GOT;
            end else begin
              estado_n = ASPERSAO;
              valor    = BCD_ASP;
            end
          end else if (ptr_q == ULTIMO) begin
            estado_n = OCIOSO;
            ptr_n    = '0;
          end else begin
            ptr_n = ptr_q + 1'b1;
          end
        end
        ASPERSAO, GOTEJAMENTO, AGRODEF: if (fim) begin
          estado_n = PAUSA;
          load     = 1'b1;
          valor    = BCD_PAUSA;
        end
        PAUSA: if (fim) begin
          load = 1'b1;
          if (ptr_q == ULTIMO) begin
            estado_n = OCIOSO;
            ptr_n    = '0;
          end else begin
            estado_n = AVALIA;
            ptr_n    = ptr_q + 1'b1;
          end
        end
        default: begin
          estado_n = OCIOSO;
          ptr_n    = '0;
          load     = 1'b1;
        end
      endcase
    end
  end

  assign sel_n     = UM << ptr_n;
  assign limpa_vec = limpa ? (UM << ptr_q) : '0;

  // Valves are registered from the next state so they change on the same
  // edge as estado.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      ptr_q    <= '0;
      pend_q   <= '0;
      asp_q    <= '0;
      got_q    <= '0;
      agro_q   <= '0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_n;
      ptr_q    <= ptr_n;
      pend_q   <= (pend_q & ~limpa_vec) | bus.agrodef_req;
      asp_q    <= (estado_n == ASPERSAO)    ? sel_n : '0;
      got_q    <= (estado_n == GOTEJAMENTO) ? sel_n : '0;
      agro_q   <= (estado_n == AGRODEF)     ? sel_n : '0;
      ocup_q   <= (estado_n != OCIOSO);
    end
  end

  assign bus.estado      = estado_q;
  assign bus.canal_ativo = ptr_q;
  assign bus.valv_asp    = asp_q;
  assign bus.valv_got    = got_q;
  assign bus.bomba_agro  = agro_q;
  assign bus.pendente    = pend_q;
  assign bus.ocupado     = ocup_q;

endmodule
